// File: rtl/hs_seq_pkg.sv
// Shared definitions for the AXI-MM handshake sequencer: bit positions of
// the master/slave level vectors, FSM state encoding and the table entry type.
package hs_seq_pkg;

    // Master level vector bit positions {rready,arvalid,bready,wvalid,awvalid}
    localparam int HS_AWV = 0;
    localparam int HS_WV  = 1;
    localparam int HS_BR  = 2;
    localparam int HS_ARV = 3;
    localparam int HS_RR  = 4;

    // Slave level vector bit positions {rvalid,arready,bvalid,wready,awready}
    localparam int HS_AWR = 0;
    localparam int HS_WR  = 1;
    localparam int HS_BV  = 2;
    localparam int HS_ARR = 3;
    localparam int HS_RV  = 4;

    // Sequencer FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Default hold-counter width and the matching table entry layout
    localparam int HS_CW = 16;

    typedef struct packed {
        logic [4:0]       master;
        logic [4:0]       slave;
        logic [HS_CW-1:0] hold;
    } hs_entry_t;

endpackage

// File: rtl/hs_pattern_ram.sv
// Pattern table: DEPTH entries of {master, slave, hold}. Written synchronously
// at any time, read combinationally so the sequencer can load the next entry
// on the same edge that retires the current one. Contents are not reset.
module hs_pattern_ram #(
    parameter int DEPTH = 16,
    parameter int CW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [4:0]    wr_master_i,
    input  logic [4:0]    wr_slave_i,
    input  logic [CW-1:0] wr_hold_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [4:0]    rd_master_o,
    output logic [4:0]    rd_slave_o,
    output logic [CW-1:0] rd_hold_o
);

    logic [4:0]    master_mem_r [DEPTH];
    logic [4:0]    slave_mem_r  [DEPTH];
    logic [CW-1:0] hold_mem_r   [DEPTH];

    // Table write port; entries keep their value across resets
    always_ff @(posedge clk) begin
        if (we_i) begin
            master_mem_r[wr_addr_i] <= wr_master_i;
            slave_mem_r[wr_addr_i]  <= wr_slave_i;
            hold_mem_r[wr_addr_i]   <= wr_hold_i;
        end
    end

    assign rd_master_o = master_mem_r[rd_addr_i];
    assign rd_slave_o  = slave_mem_r[rd_addr_i];
    assign rd_hold_o   = hold_mem_r[rd_addr_i];

endmodule

// File: rtl/handshake_sequencer.sv
// Plays back a programmed, cycle-exact sequence of AXI-MM handshake levels.
// Each table entry drives the 10 levels for hold+1 cycles; entries follow
// back to back. Run length and loop mode are latched at start.
module handshake_sequencer
    import hs_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [4:0]    cfg_master,
    input  logic [4:0]    cfg_slave,
    input  logic [CW-1:0] cfg_hold,
    input  logic [AW:0]   cfg_count,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    output logic          awvalid,
    output logic          wvalid,
    output logic          bready,
    output logic          arvalid,
    output logic          rready,
    output logic          awready,
    output logic          wready,
    output logic          bvalid,
    output logic          arready,
    output logic          rvalid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx
);

    logic [0:0]    state_q, state_d;
    logic [4:0]    master_q, master_d;
    logic [4:0]    slave_q, slave_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   count_q, count_d;
    logic          loop_q, loop_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] rd_addr_s;
    logic [4:0]    rd_master_s;
    logic [4:0]    rd_slave_s;
    logic [CW-1:0] rd_hold_s;
    logic [AW-1:0] next_idx_s;
    logic          is_last_s;
    logic [AW:0]   count_clamped_s;

    hs_pattern_ram #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .AW    (AW)
    ) u_ram (
        .clk         (clk),
        .we_i        (cfg_we),
        .wr_addr_i   (cfg_addr),
        .wr_master_i (cfg_master),
        .wr_slave_i  (cfg_slave),
        .wr_hold_i   (cfg_hold),
        .rd_addr_i   (rd_addr_s),
        .rd_master_o (rd_master_s),
        .rd_slave_o  (rd_slave_s),
        .rd_hold_o   (rd_hold_s)
    );

    // The only read targets are the following entry or, on start/wrap, entry 0
    assign next_idx_s      = idx_q + AW'(1);
    assign is_last_s       = (({1'b0, idx_q} + (AW+1)'(1)) >= count_q);
    assign rd_addr_s       = ((state_q == ST_RUN) && !is_last_s) ? next_idx_s : AW'(0);
    assign count_clamped_s = (cfg_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_count;

    // Next-state logic: start, per-entry hold countdown, advance, wrap, finish, abort
    always_comb begin
        state_d  = state_q;
        master_d = master_q;
        slave_d  = slave_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        count_d  = count_q;
        loop_d   = loop_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_count != (AW+1)'(0)) begin
                        master_d = rd_master_s;
                        slave_d  = rd_slave_s;
                        hold_d   = rd_hold_s;
                        idx_d    = AW'(0);
                        count_d  = count_clamped_s;
                        loop_d   = loop;
                        busy_d   = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    master_d = 5'd0;
                    slave_d  = 5'd0;
                    hold_d   = CW'(0);
                    idx_d    = AW'(0);
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (hold_q != CW'(0)) begin
                    hold_d   = hold_q - CW'(1);
                end else if (!is_last_s) begin
                    master_d = rd_master_s;
                    slave_d  = rd_slave_s;
                    hold_d   = rd_hold_s;
                    idx_d    = next_idx_s;
                end else if (loop_q) begin
                    master_d = rd_master_s;
                    slave_d  = rd_slave_s;
                    hold_d   = rd_hold_s;
                    idx_d    = AW'(0);
                end else begin
                    master_d = 5'd0;
                    slave_d  = 5'd0;
                    hold_d   = CW'(0);
                    idx_d    = AW'(0);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                master_d = 5'd0;
                slave_d  = 5'd0;
                hold_d   = CW'(0);
                idx_d    = AW'(0);
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            master_q <= 5'd0;
            slave_q  <= 5'd0;
            hold_q   <= CW'(0);
            idx_q    <= AW'(0);
            count_q  <= (AW+1)'(0);
            loop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            slave_q  <= slave_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            loop_q   <= loop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign awvalid  = master_q[HS_AWV];
    assign wvalid   = master_q[HS_WV];
    assign bready   = master_q[HS_BR];
    assign arvalid  = master_q[HS_ARV];
    assign rready   = master_q[HS_RR];
    assign awready  = slave_q[HS_AWR];
    assign wready   = slave_q[HS_WR];
    assign bvalid   = slave_q[HS_BV];
    assign arready  = slave_q[HS_ARR];
    assign rvalid   = slave_q[HS_RV];
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;

endmodule
